itch_msg_framer: RTL and testbench
==================================

Name: itch_msg_framer

Overview:
- Parametrised successor to the fixed-length header parser.
- Consumes a raw TCP payload byte stream of length-prefixed ITCH 5.0 messages (SoupBinTCP/MoldUDP style big-endian length field). Handles back-to-back messages of any length.
- Forwards message bodies with start/end framing, byte index, message type and per-type expected-length checking. Drops malformed messages and keeps saturating message/error counters.
- Sits between the TCP byte source and the per-type decoders (add_order_decoder and successors).

Parameters:
- LEN_FIELD_BYTES, 2, width of the length prefix in bytes (legal: 1 or 2).
- MAX_MSG_LEN, 64, largest accepted message body in bytes. Longer lengths are flagged and skipped.
- IDX_W, 6, width of byte_idx and expected_length. Must satisfy 2^IDX_W >= MAX_MSG_LEN.
- CNT_W, 16, width of the msg_count and err_count statistics counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- tcp_payload_in  in  8  stream byte.
- tcp_byte_valid_in  in  1  byte qualifier. Low = idle cycle, state held.
- flush_in  in  1  synchronous abort to length-field hunt.
- payload_out  out  8  forwarded body byte (length bytes are never forwarded).
- payload_valid_out  out  1  payload_out qualifier.
- start_flag  out  1  pulse with the first body byte (the message type byte).
- end_flag  out  1  pulse with the last body byte.
- byte_idx  out  IDX_W  index of payload_out within its body. 0 = type byte.
- msg_type  out  8  type byte of the current message, held until the next start_flag.
- expected_length  out  IDX_W  table length for msg_type. 0 if unknown type.
- length_valid  out  1  1 when the type is known and the received length equals the table length.
- len_err  out  1  pulse when the length field is 0 or greater than MAX_MSG_LEN.
- msg_count  out  CNT_W  completed messages, saturating.
- err_count  out  CNT_W  errors, saturating.

Behaviour:
- All outputs are registered. Reset value of every output is 0. Reset is asynchronous; the FSM goes to LEN with the length counter cleared.
- Latency: 1 cycle. A byte accepted at edge t appears on outputs after edge t+1.
- Pulse outputs (payload_valid_out, start_flag, end_flag, len_err) are 0 on any cycle without an accepted body byte or error.
- FSM states:
  - LEN: collect LEN_FIELD_BYTES bytes, MSB first, into msg_len (8*LEN_FIELD_BYTES bits).
  - BODY: forward msg_len bytes.
  - DROP: discard msg_len bytes.
- Transitions out of LEN on the last length byte:
  - msg_len = 0: len_err pulse, stay in LEN.
  - msg_len > MAX_MSG_LEN: len_err pulse, go to DROP.
  - Otherwise: go to BODY with the remaining-byte counter = msg_len.
- BODY:
  - Each accepted byte is forwarded with byte_idx incrementing from 0.
  - On idx 0: start_flag=1. msg_type, expected_length and length_valid update in the same cycle and hold until the next start_flag.
  - On idx msg_len-1: end_flag=1, msg_count increments, return to LEN.
  - msg_len = 1: start_flag and end_flag assert in the same cycle.
- DROP: consume msg_len bytes with no outputs, then return to LEN.
- Type table (ASCII → length): 'S'→12, 'R'→39, 'A'→36, 'F'→40, 'E'→31, 'C'→36, 'X'→23, 'D'→19, 'U'→35, 'P'→44. Any other type gives expected_length=0 and length_valid=0.
- err_count increments by 1 on each of:
  - a len_err pulse;
  - a start_flag where the type is known and length_valid=0.
  - Only one event can occur per cycle.
- Counters saturate at 2^CNT_W-1 and never wrap.
- tcp_byte_valid_in low: all state frozen, no pulses. Gaps are legal anywhere, including inside the length field.
- flush_in=1: next state is LEN with the partial length cleared and no pulses that cycle. Counters are retained. When flush_in and a valid byte coincide, flush wins and the byte is discarded.
- Message boundaries carry no bubble: the byte after end_flag is taken as the next length MSB.
- With LEN_FIELD_BYTES=1, LEN lasts exactly one accepted byte.

Test Plan:
- Default params. Stream 00 24 'A' + 35 bytes, continuous valid → start_flag with byte_idx=0 and msg_type=0x41; expected_length=36, length_valid=1; end_flag at byte_idx=35; msg_count=1; err_count=0.
- Back-to-back 'D' (00 13 + 19 bytes) then 'X' (00 17 + 23 bytes) with random valid gaps → two correct frames; bytes match input; msg_count=2.
- Length 00 00, then 01 2C (300) followed by 300 bytes, then a valid 'D' message → two len_err pulses; no payload_valid_out during the 300-byte drop; 'D' frame correct; err_count=2.
- 'A' type with length 00 20 (32) → length_valid=0, expected_length=36, err_count=1. Unknown type 'Z' length 5 → expected_length=0, err_count unchanged.
- Length 00 01 'S' → start_flag and end_flag in the same cycle, byte_idx=0.
- Mid-body flush_in (asserted with a valid byte), and separately async rst_n low mid-body → no end_flag for the aborted message; next bytes 00 13 'D'… frame correctly. After reset, all outputs are 0 and the counters are 0.

Source files
------------

// File: rtl/itch_msg_framer.sv
// itch_msg_framer: splits a raw TCP payload byte stream of length-prefixed ITCH 5.0 messages
// (big-endian length field) into framed message bodies for the per-type decoders.
//
// Ports:
//   clk, rst_n          - rising-edge clock, asynchronous active-low reset
//   tcp_payload_in      - stream byte, qualified by tcp_byte_valid_in (low = idle, state held)
//   flush_in            - synchronous abort back to length-field hunt (wins over a valid byte)
//   payload_out         - forwarded body byte, qualified by payload_valid_out
//   start_flag/end_flag - pulses with the first / last body byte
//   byte_idx            - index of payload_out within its body (0 = type byte)
//   msg_type            - type byte of the current message, held until the next start_flag
//   expected_length     - table length for msg_type (0 for unknown types)
//   length_valid        - known type and received length equals table length
//   len_err             - pulse on a zero or oversize length field
//   msg_count/err_count - saturating statistics counters
// All outputs are registered; one cycle latency from accepted byte to output.
module itch_msg_framer #(
    parameter int unsigned LEN_FIELD_BYTES = 2,
    parameter int unsigned MAX_MSG_LEN     = 64,
    parameter int unsigned IDX_W           = 6,
    parameter int unsigned CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       tcp_payload_in,
    input  logic             tcp_byte_valid_in,
    input  logic             flush_in,
    output logic [7:0]       payload_out,
    output logic             payload_valid_out,
    output logic             start_flag,
    output logic             end_flag,
    output logic [IDX_W-1:0] byte_idx,
    output logic [7:0]       msg_type,
    output logic [IDX_W-1:0] expected_length,
    output logic             length_valid,
    output logic             len_err,
    output logic [CNT_W-1:0] msg_count,
    output logic [CNT_W-1:0] err_count
);

    localparam int unsigned LW = 8 * LEN_FIELD_BYTES;

    typedef enum logic [1:0] {StLen, StBody, StDrop} state_e;

    function automatic logic [IDX_W-1:0] table_len(input logic [7:0] t);
        case (t)
            8'h53:   table_len = IDX_W'(12);  // S
            8'h52:   table_len = IDX_W'(39);  // R
            8'h41:   table_len = IDX_W'(36);  // A
            8'h46:   table_len = IDX_W'(40);  // F
            8'h45:   table_len = IDX_W'(31);  // E
            8'h43:   table_len = IDX_W'(36);  // C
            8'h58:   table_len = IDX_W'(23);  // X
            8'h44:   table_len = IDX_W'(19);  // D
            8'h55:   table_len = IDX_W'(35);  // U
            8'h50:   table_len = IDX_W'(44);  // P
            default: table_len = '0;
        endcase
    endfunction

    state_e           state_q, state_d;
    logic [1:0]       len_cnt_q, len_cnt_d;     // length bytes collected so far
    logic [LW-1:0]    len_acc_q, len_acc_d;     // partial length field
    logic [LW-1:0]    remain_q, remain_d;       // body/drop bytes still to come
    logic [IDX_W-1:0] idx_q, idx_d;             // index of the next body byte

    logic [7:0]       payload_q, payload_d;
    logic             valid_q, valid_d;
    logic             start_q, start_d;
    logic             end_q, end_d;
    logic [IDX_W-1:0] byte_idx_q, byte_idx_d;
    logic [7:0]       msg_type_q, msg_type_d;
    logic [IDX_W-1:0] exp_len_q, exp_len_d;
    logic             len_valid_q, len_valid_d;
    logic             len_err_q, len_err_d;
    logic [CNT_W-1:0] msg_cnt_q, msg_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic [LW-1:0]    new_len;
    logic [IDX_W-1:0] type_len;
    logic             msg_inc, err_inc;

    // Length field arrives MSB first; shift the partial value up by one byte.
    assign new_len  = (len_acc_q << 8) | LW'(tcp_payload_in);
    assign type_len = table_len(tcp_payload_in);

    always_comb begin
        state_d     = state_q;
        len_cnt_d   = len_cnt_q;
        len_acc_d   = len_acc_q;
        remain_d    = remain_q;
        idx_d       = idx_q;
        payload_d   = payload_q;
        valid_d     = 1'b0;
        start_d     = 1'b0;
        end_d       = 1'b0;
        byte_idx_d  = byte_idx_q;
        msg_type_d  = msg_type_q;
        exp_len_d   = exp_len_q;
        len_valid_d = len_valid_q;
        len_err_d   = 1'b0;
        msg_inc     = 1'b0;
        err_inc     = 1'b0;

        if (flush_in) begin
            state_d   = StLen;
            len_cnt_d = '0;
            len_acc_d = '0;
        end else if (tcp_byte_valid_in) begin
            case (state_q)
                StLen: begin
                    if (len_cnt_q == 2'(LEN_FIELD_BYTES - 1)) begin
                        len_cnt_d = '0;
                        len_acc_d = '0;
                        if (new_len == '0) begin
                            len_err_d = 1'b1;
                            err_inc   = 1'b1;
                        end else if (new_len > LW'(MAX_MSG_LEN)) begin
                            len_err_d = 1'b1;
                            err_inc   = 1'b1;
                            state_d   = StDrop;
                            remain_d  = new_len;
                        end else begin
                            state_d  = StBody;
                            remain_d = new_len;
                            idx_d    = '0;
                        end
                    end else begin
                        len_cnt_d = len_cnt_q + 2'd1;
                        len_acc_d = new_len;
                    end
                end
                StBody: begin
                    payload_d  = tcp_payload_in;
                    valid_d    = 1'b1;
                    byte_idx_d = idx_q;
                    idx_d      = idx_q + IDX_W'(1);
                    remain_d   = remain_q - LW'(1);
                    if (idx_q == '0) begin
                        // remain_q still holds the full body length on the type byte.
                        start_d     = 1'b1;
                        msg_type_d  = tcp_payload_in;
                        exp_len_d   = type_len;
                        len_valid_d = (type_len != '0) && (LW'(type_len) == remain_q);
                        err_inc     = (type_len != '0) && (LW'(type_len) != remain_q);
                    end
                    if (remain_q == LW'(1)) begin
                        end_d   = 1'b1;
                        msg_inc = 1'b1;
                        state_d = StLen;
                    end
                end
                StDrop: begin
                    remain_d = remain_q - LW'(1);
                    if (remain_q == LW'(1)) begin
                        state_d = StLen;
                    end
                end
                default: state_d = StLen;
            endcase
        end

        msg_cnt_d = (msg_inc && (msg_cnt_q != '1)) ? msg_cnt_q + CNT_W'(1) : msg_cnt_q;
        err_cnt_d = (err_inc && (err_cnt_q != '1)) ? err_cnt_q + CNT_W'(1) : err_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StLen;
            len_cnt_q   <= '0;
            len_acc_q   <= '0;
            remain_q    <= '0;
            idx_q       <= '0;
            payload_q   <= '0;
            valid_q     <= 1'b0;
            start_q     <= 1'b0;
            end_q       <= 1'b0;
            byte_idx_q  <= '0;
            msg_type_q  <= '0;
            exp_len_q   <= '0;
            len_valid_q <= 1'b0;
            len_err_q   <= 1'b0;
            msg_cnt_q   <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            len_cnt_q   <= len_cnt_d;
            len_acc_q   <= len_acc_d;
            remain_q    <= remain_d;
            idx_q       <= idx_d;
            payload_q   <= payload_d;
            valid_q     <= valid_d;
            start_q     <= start_d;
            end_q       <= end_d;
            byte_idx_q  <= byte_idx_d;
            msg_type_q  <= msg_type_d;
            exp_len_q   <= exp_len_d;
            len_valid_q <= len_valid_d;
            len_err_q   <= len_err_d;
            msg_cnt_q   <= msg_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign payload_out       = payload_q;
    assign payload_valid_out = valid_q;
    assign start_flag        = start_q;
    assign end_flag          = end_q;
    assign byte_idx          = byte_idx_q;
    assign msg_type          = msg_type_q;
    assign expected_length   = exp_len_q;
    assign length_valid      = len_valid_q;
    assign len_err           = len_err_q;
    assign msg_count         = msg_cnt_q;
    assign err_count         = err_cnt_q;

endmodule

// File: tb/tb_itch_msg_framer.sv
// Self-checking bench for itch_msg_framer: messages are described at message level, the
// bench derives the byte stream and the expected output records, and a monitor collects
// what the DUT actually emits.
module tb_itch_msg_framer;

    localparam int LFB  = 2;
    localparam int MAXL = 64;
    localparam int IW   = 6;
    localparam int CW   = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    din = '0;
    logic          vin = 1'b0;
    logic          flush = 1'b0;
    logic [7:0]    payload_out;
    logic          payload_valid_out;
    logic          start_flag;
    logic          end_flag;
    logic [IW-1:0] byte_idx;
    logic [7:0]    msg_type;
    logic [IW-1:0] expected_length;
    logic          length_valid;
    logic          len_err;
    logic [CW-1:0] msg_count;
    logic [CW-1:0] err_count;

    itch_msg_framer #(
        .LEN_FIELD_BYTES(LFB),
        .MAX_MSG_LEN    (MAXL),
        .IDX_W          (IW),
        .CNT_W          (CW)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .tcp_payload_in   (din),
        .tcp_byte_valid_in(vin),
        .flush_in         (flush),
        .payload_out      (payload_out),
        .payload_valid_out(payload_valid_out),
        .start_flag       (start_flag),
        .end_flag         (end_flag),
        .byte_idx         (byte_idx),
        .msg_type         (msg_type),
        .expected_length  (expected_length),
        .length_valid     (length_valid),
        .len_err          (len_err),
        .msg_count        (msg_count),
        .err_count        (err_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          err;
        logic          vld;
        logic [7:0]    data;
        logic [IW-1:0] idx;
        logic          st;
        logic          en;
        logic [7:0]    typ;
        logic [IW-1:0] expl;
        logic          lv;
    } rec_t;

    rec_t       expq[$];
    rec_t       obsq[$];
    logic [7:0] stream[$];
    int         exp_msg = 0;
    int         exp_err = 0;
    int         spurious = 0;
    int         tests_run = 0;
    int         tests_failed = 0;

    // Monitor: one record per cycle carrying a body byte or a length error.
    always @(negedge clk) begin
        if (rst_n) begin
            rec_t r;
            r = '0;
            if (!payload_valid_out && (start_flag || end_flag)) spurious++;
            if (payload_valid_out || len_err) begin
                r.err = len_err;
                r.vld = payload_valid_out;
                if (payload_valid_out) begin
                    r.data = payload_out;
                    r.idx  = byte_idx;
                    r.st   = start_flag;
                    r.en   = end_flag;
                    r.typ  = msg_type;
                    r.expl = expected_length;
                    r.lv   = length_valid;
                end
                obsq.push_back(r);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, tests run %0d", tests_run);
        $fatal(1, "watchdog");
    end

    function automatic int tbl(input logic [7:0] t);
        case (t)
            "S": return 12;
            "R": return 39;
            "A": return 36;
            "F": return 40;
            "E": return 31;
            "C": return 36;
            "X": return 23;
            "D": return 19;
            "U": return 35;
            "P": return 44;
            default: return 0;
        endcase
    endfunction

    // Append one message (length field + body) to the stream; only the first 'keep' body
    // bytes are sent, which models a message cut short by flush or reset.
    task automatic add_msg(input int len, input logic [7:0] typ, input int keep);
        rec_t       r;
        int         el;
        logic [7:0] b;
        for (int k = LFB - 1; k >= 0; k--) stream.push_back(8'((len >> (8 * k)) & 255));
        if (len == 0 || len > MAXL) begin
            r = '0;
            r.err = 1'b1;
            expq.push_back(r);
            exp_err++;
            for (int i = 0; i < len; i++) stream.push_back(8'($urandom));
            return;
        end
        el = tbl(typ);
        for (int i = 0; i < keep; i++) begin
            b = (i == 0) ? typ : 8'($urandom);
            stream.push_back(b);
            r = '0;
            r.vld  = 1'b1;
            r.data = b;
            r.idx  = IW'(i);
            r.st   = (i == 0);
            r.en   = (i == len - 1);
            r.typ  = typ;
            r.expl = IW'(el);
            r.lv   = (el != 0) && (el == len);
            expq.push_back(r);
        end
        if (keep >= 1 && el != 0 && el != len) exp_err++;
        if (keep == len) exp_msg++;
    endtask

    // Drive the queued stream with random idle gaps (gap_pct percent chance per slot).
    task automatic drive(input int gap_pct);
        for (int i = 0; i < stream.size(); i++) begin
            while ($urandom_range(0, 99) < gap_pct) begin
                vin = 1'b0;
                din = 8'($urandom);
                @(posedge clk);
                #1;
            end
            din = stream[i];
            vin = 1'b1;
            @(posedge clk);
            #1;
        end
        vin = 1'b0;
        stream.delete();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic start_test();
        obsq.delete();
        expq.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #22;
        tests_run++;
        if ({payload_out, payload_valid_out, start_flag, end_flag, byte_idx, msg_type,
             expected_length, length_valid, len_err} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got nonzero output vector, want all 0");
        end
        tests_run++;
        if ({msg_count, err_count} !== '0) begin
            tests_failed++;
            $display("FAIL reset_counters: got msg=%0d err=%0d, want 0 0", msg_count, err_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        tests_run++;
        if (payload_valid_out !== 1'b0 || msg_count !== '0) begin
            tests_failed++;
            $display("FAIL reset_idle: got valid=%b msg=%0d, want 0 0", payload_valid_out, msg_count);
        end
    endtask

    task automatic test_basic();
        start_test();
        add_msg(36, "A", 36);
        drive(0);
        tests_run++;
        if (obsq.size() !== expq.size()) begin
            tests_failed++;
            $display("FAIL basic_count: got %0d records, want %0d", obsq.size(), expq.size());
        end
        for (int i = 0; i < expq.size() && i < obsq.size(); i++) begin
            tests_run++;
            if (obsq[i] !== expq[i]) begin
                tests_failed++;
                $display("FAIL basic_rec[%0d]: got %h want %h", i, obsq[i], expq[i]);
            end
        end
        tests_run++;
        if (msg_count !== CW'(exp_msg) || err_count !== CW'(exp_err)) begin
            tests_failed++;
            $display("FAIL basic_counters: got msg=%0d err=%0d, want %0d %0d",
                     msg_count, err_count, exp_msg, exp_err);
        end
    endtask

    task automatic test_back_to_back();
        start_test();
        add_msg(19, "D", 19);
        add_msg(23, "X", 23);
        drive(30);
        tests_run++;
        if (obsq.size() !== expq.size()) begin
            tests_failed++;
            $display("FAIL b2b_count: got %0d records, want %0d", obsq.size(), expq.size());
        end
        for (int i = 0; i < expq.size() && i < obsq.size(); i++) begin
            tests_run++;
            if (obsq[i] !== expq[i]) begin
                tests_failed++;
                $display("FAIL b2b_rec[%0d]: got %h want %h", i, obsq[i], expq[i]);
            end
        end
        tests_run++;
        if (msg_count !== CW'(exp_msg) || err_count !== CW'(exp_err)) begin
            tests_failed++;
            $display("FAIL b2b_counters: got msg=%0d err=%0d, want %0d %0d",
                     msg_count, err_count, exp_msg, exp_err);
        end
    endtask

    task automatic test_len_err();
        start_test();
        add_msg(0, 8'h00, 0);
        add_msg(300, 8'h00, 0);
        add_msg(19, "D", 19);
        drive(10);
        tests_run++;
        if (obsq.size() !== expq.size()) begin
            tests_failed++;
            $display("FAIL lenerr_count: got %0d records, want %0d", obsq.size(), expq.size());
        end
        for (int i = 0; i < expq.size() && i < obsq.size(); i++) begin
            tests_run++;
            if (obsq[i] !== expq[i]) begin
                tests_failed++;
                $display("FAIL lenerr_rec[%0d]: got %h want %h", i, obsq[i], expq[i]);
            end
        end
        tests_run++;
        if (msg_count !== CW'(exp_msg) || err_count !== CW'(exp_err)) begin
            tests_failed++;
            $display("FAIL lenerr_counters: got msg=%0d err=%0d, want %0d %0d",
                     msg_count, err_count, exp_msg, exp_err);
        end
    endtask

    task automatic test_length_check();
        start_test();
        add_msg(32, "A", 32);
        add_msg(5, "Z", 5);
        drive(20);
        tests_run++;
        if (obsq.size() !== expq.size()) begin
            tests_failed++;
            $display("FAIL lencheck_count: got %0d records, want %0d", obsq.size(), expq.size());
        end
        for (int i = 0; i < expq.size() && i < obsq.size(); i++) begin
            tests_run++;
            if (obsq[i] !== expq[i]) begin
                tests_failed++;
                $display("FAIL lencheck_rec[%0d]: got %h want %h", i, obsq[i], expq[i]);
            end
        end
        tests_run++;
        if (msg_count !== CW'(exp_msg) || err_count !== CW'(exp_err)) begin
            tests_failed++;
            $display("FAIL lencheck_counters: got msg=%0d err=%0d, want %0d %0d",
                     msg_count, err_count, exp_msg, exp_err);
        end
    endtask

    task automatic test_single_byte();
        start_test();
        add_msg(1, "S", 1);
        add_msg(1, 8'h21, 1);
        drive(0);
        tests_run++;
        if (obsq.size() !== expq.size()) begin
            tests_failed++;
            $display("FAIL single_count: got %0d records, want %0d", obsq.size(), expq.size());
        end
        for (int i = 0; i < expq.size() && i < obsq.size(); i++) begin
            tests_run++;
            if (obsq[i] !== expq[i]) begin
                tests_failed++;
                $display("FAIL single_rec[%0d]: got %h want %h", i, obsq[i], expq[i]);
            end
        end
        tests_run++;
        if (msg_count !== CW'(exp_msg) || err_count !== CW'(exp_err)) begin
            tests_failed++;
            $display("FAIL single_counters: got msg=%0d err=%0d, want %0d %0d",
                     msg_count, err_count, exp_msg, exp_err);
        end
    endtask

    task automatic flush_cycle();
        din   = 8'($urandom);
        vin   = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        vin   = 1'b0;
    endtask

    task automatic test_flush();
        start_test();
        add_msg(36, "A", 11);
        drive(10);
        flush_cycle();
        stream.push_back(8'h7f);  // lone length MSB that the flush must discard
        drive(0);
        flush_cycle();
        add_msg(19, "D", 19);
        drive(10);
        tests_run++;
        if (obsq.size() !== expq.size()) begin
            tests_failed++;
            $display("FAIL flush_count: got %0d records, want %0d", obsq.size(), expq.size());
        end
        for (int i = 0; i < expq.size() && i < obsq.size(); i++) begin
            tests_run++;
            if (obsq[i] !== expq[i]) begin
                tests_failed++;
                $display("FAIL flush_rec[%0d]: got %h want %h", i, obsq[i], expq[i]);
            end
        end
        tests_run++;
        if (msg_count !== CW'(exp_msg) || err_count !== CW'(exp_err) || spurious !== 0) begin
            tests_failed++;
            $display("FAIL flush_counters: got msg=%0d err=%0d spurious=%0d, want %0d %0d 0",
                     msg_count, err_count, spurious, exp_msg, exp_err);
        end
    endtask

    task automatic test_async_reset();
        start_test();
        add_msg(36, "A", 5);
        drive(0);
        tests_run++;
        if (obsq.size() !== expq.size()) begin
            tests_failed++;
            $display("FAIL areset_pre_count: got %0d records, want %0d", obsq.size(), expq.size());
        end
        for (int i = 0; i < expq.size() && i < obsq.size(); i++) begin
            tests_run++;
            if (obsq[i] !== expq[i]) begin
                tests_failed++;
                $display("FAIL areset_pre_rec[%0d]: got %h want %h", i, obsq[i], expq[i]);
            end
        end
        #2;
        rst_n = 1'b0;  // asserted between clock edges
        #1;
        tests_run++;
        if ({payload_out, payload_valid_out, start_flag, end_flag, byte_idx, msg_type,
             expected_length, length_valid, len_err, msg_count, err_count} !== '0) begin
            tests_failed++;
            $display("FAIL areset_outputs: got msg=%0d err=%0d type=%h, want all outputs 0",
                     msg_count, err_count, msg_type);
        end
        exp_msg = 0;
        exp_err = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        start_test();
        add_msg(19, "D", 19);
        drive(15);
        tests_run++;
        if (obsq.size() !== expq.size()) begin
            tests_failed++;
            $display("FAIL areset_count: got %0d records, want %0d", obsq.size(), expq.size());
        end
        for (int i = 0; i < expq.size() && i < obsq.size(); i++) begin
            tests_run++;
            if (obsq[i] !== expq[i]) begin
                tests_failed++;
                $display("FAIL areset_rec[%0d]: got %h want %h", i, obsq[i], expq[i]);
            end
        end
        tests_run++;
        if (msg_count !== CW'(exp_msg) || err_count !== CW'(exp_err) || spurious !== 0) begin
            tests_failed++;
            $display("FAIL areset_counters: got msg=%0d err=%0d spurious=%0d, want %0d %0d 0",
                     msg_count, err_count, spurious, exp_msg, exp_err);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_len_err();
        test_length_check();
        test_single_byte();
        test_flush();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
